// File: rtl/rv32i_load_store_unit_if.sv
// Purpose : bundles the core-side request/response and data-memory bus signals of the LSU.
// Latency : none, wiring only.
// Backpressure: req_valid/req_ready toward the core; bus_valid/bus_ready plus bus_rvalid toward memory.
// Ports   : req_* (memory op from decode), resp_* (completion pulse), bus_* (word-addressed data bus).
// Modports: slave = the load/store unit; master = the core FSM plus the data memory around it.
interface rv32i_load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  bus_valid;
  logic                  bus_ready;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_be;
  logic [31:0]           bus_wdata;
  logic                  bus_rvalid;
  logic [31:0]           bus_rdata;

  modport slave (
    input  req_valid, req_op, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport master (
    output req_valid, req_op, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/rv32i_load_store_unit.sv
// Purpose : RV32I memory-stage executor; turns LOAD/STORE/MEM_NOOP ops into data-bus accesses.
// Latency : accept T; store resp T+2, load resp T+3 (earliest bus), noop/error resp T+1.
// Backpressure: req_ready only in IDLE; waits on bus_ready/bus_rvalid up to TIMEOUT_CYCLES (0 = forever).
// Ports   : clk, reset (synchronous, active-high), lsu (rv32i_load_store_unit_if.slave).
// Option  : define LSU_MISALIGNED_SPLIT_EN to allow misaligned accesses (crossing ones split in two).
module rv32i_load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  rv32i_load_store_unit_if.slave lsu
);
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_ACCESS, S_RDWAIT, S_RESP
`ifdef LSU_MISALIGNED_SPLIT_EN
    , S_ACCESS2, S_RDWAIT2
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic                  we_q, we_d;
  logic [7:0]            be_q, be_d;     // [3:0] first access, [7:4] second access
  logic [63:0]           wd_q, wd_d;     // [31:0] first access, [63:32] second access
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [31:0]           rlo_q, rlo_d;   // first-access load word of a crossing load
`endif

  // Shift the raw (possibly two-word) load data down to the addressed byte, then extend.
  function automatic logic [31:0] load_extract(input logic [63:0] raw, input logic [1:0] ofs,
                                               input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = 32'(raw >> {ofs, 3'b000});
    case (size)
      SZ_BYTE: load_extract = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: load_extract = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

  // Request decode, used only at acceptance.
  logic [1:0]  ofs_in;
  logic [3:0]  mask_in;
  logic [7:0]  be_in;
  logic [31:0] repl_in;
  logic [63:0] wd_in;
  logic        misal_in, misal_err_in, bad_size_in, is_mem_in;

  always_comb begin
    ofs_in      = lsu.req_addr[1:0];
    bad_size_in = (lsu.req_size == 2'b11);
    is_mem_in   = (lsu.req_op == OP_LOAD) || (lsu.req_op == OP_STORE);
    misal_in    = ((lsu.req_size == SZ_HALF) && ofs_in[0]) ||
                  ((lsu.req_size == SZ_WORD) && (ofs_in != 2'b00));
    case (lsu.req_size)
      SZ_BYTE: begin mask_in = 4'b0001; repl_in = {4{lsu.req_wdata[7:0]}};  end
      SZ_HALF: begin mask_in = 4'b0011; repl_in = {2{lsu.req_wdata[15:0]}}; end
      default: begin mask_in = 4'b1111; repl_in = lsu.req_wdata;            end
    endcase
    be_in = {4'b0000, mask_in} << ofs_in;
`ifdef LSU_MISALIGNED_SPLIT_EN
    misal_err_in = 1'b0;
    // Misaligned stores place bytes by shifting across the two-word window.
    wd_in = misal_in ? ({32'b0, lsu.req_wdata} << {ofs_in, 3'b000}) : {32'b0, repl_in};
`else
    misal_err_in = misal_in;
    wd_in        = {32'b0, repl_in};
`endif
  end

  logic waiting, crossing;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    be_d    = be_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    waiting = 1'b0;
    crossing = |be_q[7:4];
`ifdef LSU_MISALIGNED_SPLIT_EN
    rlo_d   = rlo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (lsu.req_valid) begin
          addr_d  = lsu.req_addr;
          size_d  = lsu.req_size;
          uns_d   = lsu.req_unsigned;
          we_d    = (lsu.req_op == OP_STORE);
          be_d    = be_in;
          wd_d    = wd_in;
          rdata_d = 32'b0;
          err_d   = 1'b0;
          // A noop completes cleanly even if its size field is garbage.
          if (!is_mem_in) begin
            state_d = S_RESP;
          end else if (bad_size_in || misal_err_in) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        waiting = 1'b1;
        if (lsu.bus_ready) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (we_q) state_d = crossing ? S_ACCESS2 : S_RESP;
          else      state_d = S_RDWAIT;
`else
          state_d = we_q ? S_RESP : S_RDWAIT;
`endif
        end
      end
      S_RDWAIT: begin
        waiting = 1'b1;
        if (lsu.bus_rvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (crossing) begin
            rlo_d   = lsu.bus_rdata;
            state_d = S_ACCESS2;
          end else begin
            rdata_d = load_extract({32'b0, lsu.bus_rdata}, addr_q[1:0], size_q, uns_q);
            state_d = S_RESP;
          end
`else
          rdata_d = load_extract({32'b0, lsu.bus_rdata}, addr_q[1:0], size_q, uns_q);
          state_d = S_RESP;
`endif
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      S_ACCESS2: begin
        waiting = 1'b1;
        if (lsu.bus_ready) state_d = we_q ? S_RESP : S_RDWAIT2;
      end
      S_RDWAIT2: begin
        waiting = 1'b1;
        if (lsu.bus_rvalid) begin
          rdata_d = load_extract({lsu.bus_rdata, rlo_q}, addr_q[1:0], size_q, uns_q);
          state_d = S_RESP;
        end
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort only when the bus made no progress this cycle and the budget is spent.
    if (waiting && (state_d == state_q) && (TIMEOUT_CYCLES != 0) &&
        (cnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
      state_d = S_RESP;
      err_d   = 1'b1;
      rdata_d = 32'b0;
    end
    cnt_d = (waiting && (state_d == state_q)) ? cnt_q + 32'd1 : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      rlo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
      rlo_q   <= rlo_d;
`endif
    end
  end

  logic                  phase2;
  logic [ADDR_WIDTH-1:0] base_addr;
`ifdef LSU_MISALIGNED_SPLIT_EN
  assign phase2 = (state_q == S_ACCESS2) || (state_q == S_RDWAIT2);
`else
  assign phase2 = 1'b0;
`endif
  assign base_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  assign lsu.req_ready  = (state_q == S_IDLE) && !reset;
  assign lsu.resp_valid = (state_q == S_RESP);
  assign lsu.resp_err   = (state_q == S_RESP) && err_q;
  assign lsu.resp_rdata = (state_q == S_RESP) ? rdata_q : 32'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
  assign lsu.bus_valid  = (state_q == S_ACCESS) || (state_q == S_ACCESS2);
`else
  assign lsu.bus_valid  = (state_q == S_ACCESS);
`endif
  assign lsu.bus_we     = we_q;
  assign lsu.bus_addr   = phase2 ? base_addr + ADDR_WIDTH'(4) : base_addr;
  assign lsu.bus_be     = phase2 ? be_q[7:4] : be_q[3:0];
  assign lsu.bus_wdata  = phase2 ? wd_q[63:32] : wd_q[31:0];
endmodule

// File: tb/tb_rv32i_load_store_unit.sv
module tb_rv32i_load_store_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32i_load_store_unit_if #(.ADDR_WIDTH(32)) lsu_if ();

  rv32i_load_store_unit #(.TIMEOUT_CYCLES(16), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .lsu   (lsu_if.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;   // data the memory model returns
    int          lat;      // cycles from accept to resp_valid
    logic        err;
    logic [31:0] rdata;
    int          nbus;     // cycles with bus_valid high
    logic        we;
    logic [31:0] addr0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] addr1;
    logic [3:0]  be1;
    logic [31:0] wd1;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one op at the current negedge; the memory model answers at the earliest legal cycle.
  task automatic run_op(input vec_t v);
    int          lat = 0;
    int          nb = 0;
    bit          got = 0;
    bit          pend = 0;
    logic [31:0] c_addr [2];
    logic [3:0]  c_be [2];
    logic [31:0] c_wd [2];
    logic        c_we = 1'b0;
    logic [31:0] r_dat = '0;
    logic        r_err = 1'b0;
    for (int k = 0; k < 2; k++) begin c_addr[k] = '0; c_be[k] = '0; c_wd[k] = '0; end
    chk({v.name, ".ready"}, 32'(lsu_if.req_ready), 32'd1);
    lsu_if.req_valid    = 1'b1;
    lsu_if.req_op       = v.op;
    lsu_if.req_size     = v.size;
    lsu_if.req_unsigned = v.uns;
    lsu_if.req_addr     = v.addr;
    lsu_if.req_wdata    = v.wdata;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      lsu_if.req_valid  = 1'b0;
      lsu_if.bus_ready  = 1'b0;
      lsu_if.bus_rvalid = 1'b0;
      lat++;
      if (pend) begin
        lsu_if.bus_rvalid = 1'b1;
        lsu_if.bus_rdata  = v.brdata;
        pend = 0;
      end
      if (lsu_if.bus_valid) begin
        if (nb < 2) begin
          c_addr[nb] = lsu_if.bus_addr;
          c_be[nb]   = lsu_if.bus_be;
          c_wd[nb]   = lsu_if.bus_wdata;
        end
        c_we = lsu_if.bus_we;
        nb++;
        lsu_if.bus_ready = 1'b1;
        if (!lsu_if.bus_we) pend = 1;
      end
      if (lsu_if.resp_valid) begin
        got   = 1;
        r_dat = lsu_if.resp_rdata;
        r_err = lsu_if.resp_err;
      end
    end
    if (!got) lat = 0;
    chk({v.name, ".lat"},   32'(lat), 32'(v.lat));
    chk({v.name, ".err"},   32'(r_err), 32'(v.err));
    chk({v.name, ".rdata"}, r_dat, v.rdata);
    chk({v.name, ".nbus"},  32'(nb), 32'(v.nbus));
    if (v.nbus > 0) begin
      chk({v.name, ".we"},    32'(c_we), 32'(v.we));
      chk({v.name, ".addr0"}, c_addr[0], v.addr0);
      chk({v.name, ".be0"},   32'(c_be[0]), 32'(v.be0));
      if (v.we) chk({v.name, ".wd0"}, c_wd[0], v.wd0);
    end
    if (v.nbus > 1) begin
      chk({v.name, ".addr1"}, c_addr[1], v.addr1);
      chk({v.name, ".be1"},   32'(c_be[1]), 32'(v.be1));
      if (v.we) chk({v.name, ".wd1"}, c_wd[1], v.wd1);
    end
    @(negedge clk);
    lsu_if.bus_ready  = 1'b0;
    lsu_if.bus_rvalid = 1'b0;
    chk({v.name, ".pulse"}, 32'(lsu_if.resp_valid), 32'd0);
    chk({v.name, ".idle"},  32'(lsu_if.req_ready), 32'd1);
  endtask

  initial begin
    int          cnt;
    bit          got;
    logic        r_err;
    logic [31:0] r_dat;

    //        name    op     size   u  addr          wdata         brdata        lat err rdata        nb we addr0         be0      wd0           addr1         be1      wd1
    vt[0]  = '{"LW",   2'b00, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 3, 0, 32'hDEADBEEF, 1, 0, 32'h100, 4'b1111, 32'h0,        32'h0, 4'b0, 32'h0};
    vt[1]  = '{"LB",   2'b00, 2'b00, 0, 32'h103, 32'h0,        32'h80112233, 3, 0, 32'hFFFFFF80, 1, 0, 32'h100, 4'b1000, 32'h0,        32'h0, 4'b0, 32'h0};
    vt[2]  = '{"LBU",  2'b00, 2'b00, 1, 32'h103, 32'h0,        32'h80112233, 3, 0, 32'h00000080, 1, 0, 32'h100, 4'b1000, 32'h0,        32'h0, 4'b0, 32'h0};
    vt[3]  = '{"LH2",  2'b00, 2'b01, 0, 32'h102, 32'h0,        32'h80112233, 3, 0, 32'hFFFF8011, 1, 0, 32'h100, 4'b1100, 32'h0,        32'h0, 4'b0, 32'h0};
    vt[4]  = '{"LHU0", 2'b00, 2'b01, 1, 32'h100, 32'h0,        32'h80112233, 3, 0, 32'h00002233, 1, 0, 32'h100, 4'b0011, 32'h0,        32'h0, 4'b0, 32'h0};
    vt[5]  = '{"LB1",  2'b00, 2'b00, 0, 32'h101, 32'h0,        32'h80112233, 3, 0, 32'h00000022, 1, 0, 32'h100, 4'b0010, 32'h0,        32'h0, 4'b0, 32'h0};
    vt[6]  = '{"SH",   2'b01, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h0,        2, 0, 32'h0,        1, 1, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0, 4'b0, 32'h0};
    vt[7]  = '{"SB",   2'b01, 2'b00, 0, 32'h005, 32'h123456A5, 32'h0,        2, 0, 32'h0,        1, 1, 32'h004, 4'b0010, 32'hA5A5A5A5, 32'h0, 4'b0, 32'h0};
    vt[8]  = '{"SW",   2'b01, 2'b10, 0, 32'h300, 32'h11223344, 32'h0,        2, 0, 32'h0,        1, 1, 32'h300, 4'b1111, 32'h11223344, 32'h0, 4'b0, 32'h0};
`ifdef LSU_MISALIGNED_SPLIT_EN
    vt[9]  = '{"SWm",  2'b01, 2'b10, 0, 32'h301, 32'h11223344, 32'h0,        3, 0, 32'h0,        2, 1, 32'h300, 4'b1110, 32'h22334400, 32'h304, 4'b0001, 32'h00000011};
    vt[10] = '{"LHm",  2'b00, 2'b01, 0, 32'h101, 32'h0,        32'h80112233, 3, 0, 32'h00001122, 1, 0, 32'h100, 4'b0110, 32'h0,        32'h0, 4'b0, 32'h0};
`else
    vt[9]  = '{"SWm",  2'b01, 2'b10, 0, 32'h301, 32'h11223344, 32'h0,        1, 1, 32'h0,        0, 1, 32'h0,   4'b0,    32'h0,        32'h0, 4'b0, 32'h0};
    vt[10] = '{"LHm",  2'b00, 2'b01, 0, 32'h101, 32'h0,        32'h80112233, 1, 1, 32'h0,        0, 0, 32'h0,   4'b0,    32'h0,        32'h0, 4'b0, 32'h0};
`endif
    vt[11] = '{"NOOP", 2'b11, 2'b10, 0, 32'h100, 32'h0,        32'h0,        1, 0, 32'h0,        0, 0, 32'h0,   4'b0,    32'h0,        32'h0, 4'b0, 32'h0};
    vt[12] = '{"OP10", 2'b10, 2'b10, 0, 32'h100, 32'h0,        32'h0,        1, 0, 32'h0,        0, 0, 32'h0,   4'b0,    32'h0,        32'h0, 4'b0, 32'h0};
    vt[13] = '{"SZ11", 2'b00, 2'b11, 0, 32'h100, 32'h0,        32'h0,        1, 1, 32'h0,        0, 0, 32'h0,   4'b0,    32'h0,        32'h0, 4'b0, 32'h0};
    vt[14] = '{"LWU",  2'b00, 2'b10, 1, 32'h104, 32'h0,        32'h80000001, 3, 0, 32'h80000001, 1, 0, 32'h104, 4'b1111, 32'h0,        32'h0, 4'b0, 32'h0};
    vt[15] = '{"LHU2", 2'b00, 2'b01, 1, 32'h102, 32'h0,        32'h80112233, 3, 0, 32'h00008011, 1, 0, 32'h100, 4'b1100, 32'h0,        32'h0, 4'b0, 32'h0};

    reset = 1'b1;
    lsu_if.req_valid    = 1'b0;
    lsu_if.req_op       = 2'b11;
    lsu_if.req_size     = 2'b10;
    lsu_if.req_unsigned = 1'b0;
    lsu_if.req_addr     = '0;
    lsu_if.req_wdata    = '0;
    lsu_if.bus_ready    = 1'b0;
    lsu_if.bus_rvalid   = 1'b0;
    lsu_if.bus_rdata    = '0;

    // Reset state, sampled while reset is still asserted.
    @(negedge clk);
    @(negedge clk);
    chk("rst.req_ready",  32'(lsu_if.req_ready), 32'd0);
    chk("rst.resp_valid", 32'(lsu_if.resp_valid), 32'd0);
    chk("rst.resp_err",   32'(lsu_if.resp_err), 32'd0);
    chk("rst.bus_valid",  32'(lsu_if.bus_valid), 32'd0);
    chk("rst.bus_we",     32'(lsu_if.bus_we), 32'd0);
    chk("rst.resp_rdata", lsu_if.resp_rdata, 32'd0);
    chk("rst.bus_addr",   lsu_if.bus_addr, 32'd0);
    chk("rst.bus_be",     32'(lsu_if.bus_be), 32'd0);
    chk("rst.bus_wdata",  lsu_if.bus_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.ready_after", 32'(lsu_if.req_ready), 32'd1);

    for (int i = 0; i < NV; i++) run_op(vt[i]);

    // Timeout: bus_ready never rises.
    lsu_if.req_valid = 1'b1;
    lsu_if.req_op    = 2'b00;
    lsu_if.req_size  = 2'b10;
    lsu_if.req_addr  = 32'h400;
    @(negedge clk);
    lsu_if.req_valid = 1'b0;
    cnt = 0;
    got = 0;
    r_err = 1'b0;
    r_dat = 32'hFFFFFFFF;
    for (int c = 0; c < 60 && !got; c++) begin
      if (lsu_if.bus_valid) cnt++;
      if (lsu_if.resp_valid) begin
        got   = 1;
        r_err = lsu_if.resp_err;
        r_dat = lsu_if.resp_rdata;
      end else begin
        @(negedge clk);
      end
    end
    chk("to.resp_seen",  32'(got), 32'd1);
    chk("to.bus_cycles", 32'(cnt), 32'd16);
    chk("to.err",        32'(r_err), 32'd1);
    chk("to.rdata",      r_dat, 32'd0);
    @(negedge clk);
    chk("to.ready", 32'(lsu_if.req_ready), 32'd1);
    // Late rvalid while idle must not produce a response.
    lsu_if.bus_rvalid = 1'b1;
    lsu_if.bus_rdata  = 32'h12345678;
    @(negedge clk);
    lsu_if.bus_rvalid = 1'b0;
    chk("late.resp_valid", 32'(lsu_if.resp_valid), 32'd0);
    chk("late.ready",      32'(lsu_if.req_ready), 32'd1);
    @(negedge clk);
    chk("late.resp_valid2", 32'(lsu_if.resp_valid), 32'd0);

    // Reset while the load sits in RDWAIT.
    lsu_if.req_valid = 1'b1;
    lsu_if.req_op    = 2'b00;
    lsu_if.req_size  = 2'b10;
    lsu_if.req_addr  = 32'h500;
    @(negedge clk);
    lsu_if.req_valid = 1'b0;
    chk("mid.bus_valid", 32'(lsu_if.bus_valid), 32'd1);
    lsu_if.bus_ready = 1'b1;
    @(negedge clk);
    lsu_if.bus_ready = 1'b0;
    chk("mid.rdwait_bus_valid", 32'(lsu_if.bus_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid.rst_bus_valid",  32'(lsu_if.bus_valid), 32'd0);
    chk("mid.rst_resp_valid", 32'(lsu_if.resp_valid), 32'd0);
    chk("mid.rst_req_ready",  32'(lsu_if.req_ready), 32'd0);
    chk("mid.rst_bus_addr",   lsu_if.bus_addr, 32'd0);
    chk("mid.rst_bus_be",     32'(lsu_if.bus_be), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid.no_resp", 32'(lsu_if.resp_valid), 32'd0);
    run_op(vt[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
